// File: rtl/riscv_lsu.sv
// Load/store unit: turns core data requests into word-aligned, byte-enabled memory transactions.
// Optional BUSY watchdog enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;

  logic        busy, timeout, is_byte, is_half;
  logic [3:0]  be;
  logic [31:0] lane_wd, shifted, load_val;
  logic [15:0] half;

  assign busy    = (state_q == StBusy);
  // funct3 codes 2, 3, 6 and 7 all fall through to word access.
  assign is_byte = (size_q[1:0] == 2'b00);
  assign is_half = (size_q[1:0] == 2'b01);

  always_comb begin
    be      = 4'b1111;
    lane_wd = wd_q;
    if (is_byte) begin
      be      = 4'b0001 << addr_q[1:0];
      lane_wd = {4{wd_q[7:0]}};
    end else if (is_half) begin
      be      = addr_q[1] ? 4'b1100 : 4'b0011;
      lane_wd = {2{wd_q[15:0]}};
    end
  end

  // size_q[2] marks the unsigned load variants.
  always_comb begin
    shifted  = mem_rd_i >> {addr_q[1:0], 3'b000};
    half     = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    load_val = mem_rd_i;
    if (is_byte) begin
      load_val = {{24{shifted[7] & ~size_q[2]}}, shifted[7:0]};
    end else if (is_half) begin
      load_val = {{16{half[15] & ~size_q[2]}}, half};
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q;

  assign timeout = busy & ~mem_ready_i & (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && core_req_i) begin
      cnt_d = '0;
    end else if (busy && !mem_ready_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    size_d  = size_q;
    we_d    = we_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        if (core_req_i) begin
          addr_d  = core_addr_i;
          wd_d    = core_wd_i;
          size_d  = core_size_i;
          we_d    = core_we_i;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (mem_ready_i) begin
          if (!we_q) begin
            rd_d = load_val;
          end
          state_d = StDone;
        end else if (timeout) begin
          rd_d    = 32'hDEAD_BEEF;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wd_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
    end
  end

  assign mem_req_o    = busy;
  assign mem_we_o     = busy & we_q;
  assign mem_be_o     = busy ? be : 4'b0000;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wd_o     = lane_wd;
  assign core_rd_o    = rd_q;
  assign core_stall_o = core_req_i & (state_q != StDone);

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed table, corner sequences and random transactions.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i, mem_ready_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, mem_rd_i;
  logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
  logic        core_stall_o, mem_req_o, mem_we_o, err_o;
  logic [3:0]  mem_be_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rd = 32'h0;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .core_req_i  (core_req_i),
    .core_we_i   (core_we_i),
    .core_size_i (core_size_i),
    .core_addr_i (core_addr_i),
    .core_wd_i   (core_wd_i),
    .core_rd_o   (core_rd_o),
    .core_stall_o(core_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wd_o    (mem_wd_o),
    .mem_rd_i    (mem_rd_i),
    .mem_ready_i (mem_ready_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access width in bytes from funct3.
  function automatic int m_nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int m_off(input logic [2:0] sz, input logic [31:0] a);
    int n = m_nbytes(sz);
    if (n == 4) return 0;
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
    int n = m_nbytes(sz);
    return 4'(((1 << n) - 1) << m_off(sz, a));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
    int n = m_nbytes(sz);
    if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] sz, input logic [31:0] a,
                                      input logic [31:0] mrd);
    int n = m_nbytes(sz);
    logic [31:0] v;
    if (n == 4) return mrd;
    v = (mrd >> (8 * m_off(sz, a))) & ((n == 1) ? 32'hFF : 32'hFFFF);
    if (sz < 3'd4) begin
      if (n == 1 && v >= 32'h80)   v = v - 32'h100;
      if (n == 2 && v >= 32'h8000) v = v - 32'h1_0000;
    end
    return v;
  endfunction

  // Starts in an IDLE cycle just after an edge; returns in the DONE cycle.
  task automatic run_txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mrd, input int dly,
                         input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
    int stalls = 0;
    int reqs   = 0;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i   = wd;
    mem_ready_i = 1'($urandom % 2);
    mem_rd_i    = $urandom;
    #1;
    chk("idle_stall", core_stall_o, 1);
    chk("idle_mem_req", mem_req_o, 0);
    if (core_stall_o) stalls++;
    tick();
    core_addr_i = $urandom;
    core_wd_i   = $urandom;
    for (int i = 0; i <= dly; i++) begin
      mem_ready_i = (i == dly);
      mem_rd_i    = (i == dly) ? mrd : $urandom;
      #1;
      chk("busy_addr", mem_addr_o, {a[31:2], 2'b00});
      chk("busy_be", mem_be_o, ebe);
      chk("busy_we", mem_we_o, we);
      if (we) chk("busy_wd", mem_wd_o, ewd);
      if (core_stall_o) stalls++;
      if (mem_req_o) reqs++;
      tick();
    end
    mem_ready_i = 1'b0;
    #1;
    chk("done_stall", core_stall_o, 0);
    chk("done_mem_req", mem_req_o, 0);
    chk("done_be", mem_be_o, 0);
    chk("done_rd", core_rd_o, erd);
    chk("done_err", err_o, 0);
    chk("stall_cycles", stalls, dly + 2);
    chk("req_cycles", reqs, dly + 1);
    core_req_i = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a, wd, mrd;
    int          dly;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0, 32'h8899AABB, 0, 4'b1111, 32'h0, 32'h8899AABB});
    vecs.push_back('{1'b0, 3'd0, 32'h103, 32'h0, 32'h8899AABB, 1, 4'b1000, 32'h0, 32'hFFFFFF88});
    vecs.push_back('{1'b0, 3'd4, 32'h103, 32'h0, 32'h8899AABB, 0, 4'b1000, 32'h0, 32'h00000088});
    vecs.push_back('{1'b0, 3'd5, 32'h102, 32'h0, 32'h8899AABB, 2, 4'b1100, 32'h0, 32'h00008899});
    vecs.push_back('{1'b0, 3'd1, 32'h101, 32'h0, 32'h8899AABB, 0, 4'b0011, 32'h0, 32'hFFFFAABB});
    vecs.push_back('{1'b1, 3'd0, 32'h201, 32'h12345678, 32'h0, 0, 4'b0010, 32'h78787878,
                     32'hFFFFAABB});
    vecs.push_back('{1'b1, 3'd1, 32'h202, 32'h12345678, 32'h0, 3, 4'b1100, 32'h56785678,
                     32'hFFFFAABB});
    vecs.push_back('{1'b0, 3'd7, 32'h003, 32'h0, 32'h8899AABB, 0, 4'b1111, 32'h0, 32'h8899AABB});
    vecs.push_back('{1'b1, 3'd2, 32'h007, 32'hCAFEF00D, 32'h0, 1, 4'b1111, 32'hCAFEF00D,
                     32'h8899AABB});

    rst_i = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'h0; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wd", mem_wd_o, 0);
    chk("rst_rd", core_rd_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].mrd, vecs[i].dly,
              vecs[i].ebe, vecs[i].ewd, vecs[i].erd);
      tick();
    end
    last_rd = 32'h8899AABB;

`ifndef LSU_TIMEOUT_EN
    // Long ready delays complete normally when the watchdog is not built in.
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, 32'h01020304, 4, 4'b1111, 32'h0, 32'h01020304);
    tick();
    run_txn(1'b0, 3'd0, 32'h42, 32'h0, 32'h00A50000, 9, 4'b0100, 32'h0, 32'hFFFFFFA5);
    tick();
    last_rd = 32'hFFFFFFA5;
`else
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h80;
    tick();
    core_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rd_i = $urandom;
      #1;
      chk("to_busy_req", mem_req_o, 1);
      tick();
    end
    chk("to_done_req", mem_req_o, 0);
    chk("to_done_rd", core_rd_o, 32'hDEADBEEF);
    chk("to_done_err", err_o, 1);
    core_req_i = 1'b1;
    #1;
    chk("to_done_stall", core_stall_o, 0);
    core_req_i = 1'b0;
    tick();
    chk("to_err_pulse", err_o, 0);
    last_rd = 32'hDEADBEEF;
`endif

    // Request withdrawn mid-BUSY still completes and updates core_rd_o.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd4; core_addr_i = 32'h101;
    tick();
    core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'h11223344;
    #1;
    chk("drop_stall", core_stall_o, 0);
    chk("drop_mem_req", mem_req_o, 1);
    tick();
    mem_ready_i = 1'b0;
    chk("drop_rd", core_rd_o, 32'h00000033);
    tick();

    // Reset while BUSY abandons the transaction.
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd0; core_addr_i = 32'h301;
    core_wd_i = 32'hABCD;
    tick();
    chk("prerst_mem_req", mem_req_o, 1);
    rst_i = 1'b0; core_req_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("midrst_mem_req", mem_req_o, 0);
    chk("midrst_we", mem_we_o, 0);
    chk("midrst_be", mem_be_o, 0);
    chk("midrst_addr", mem_addr_o, 0);
    chk("midrst_wd", mem_wd_o, 0);
    chk("midrst_rd", core_rd_o, 0);
    chk("midrst_stall", core_stall_o, 0);
    last_rd = 32'h0;
    // Immediate 3-cycle access proves the FSM came back in IDLE.
    run_txn(1'b0, 3'd2, 32'h10, 32'h0, 32'h5555AAAA, 0, 4'b1111, 32'h0, 32'h5555AAAA);
    tick();
    last_rd = 32'h5555AAAA;

    for (int k = 0; k < 150; k++) begin
      logic        we;
      logic [2:0]  sz;
      logic [31:0] a, wd, mrd, erd;
      int          dly;
      we  = 1'($urandom % 2);
      sz  = 3'($urandom % 8);
      a   = $urandom;
      wd  = $urandom;
      mrd = $urandom;
      dly = $urandom_range(0, 3);
      erd = we ? last_rd : m_rd(sz, a, mrd);
      run_txn(we, sz, a, wd, mrd, dly, m_be(sz, a), m_wd(sz, wd), erd);
      last_rd = erd;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit acting as the responder to the core's data-memory interface: it accepts the core's request/size/address/write-data, converts it into a word-aligned, byte-enabled transaction on an external memory port with a ready handshake, and holds the core stalled until the transaction completes. On loads it extracts the addressed byte or halfword and sign- or zero-extends it before returning it to the core. It sits between `riscv_core` (data port and `stall_i`) and the data RAM or peripheral bus.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent waiting in BUSY for `mem_ready_i`; used only with `LSU_TIMEOUT_EN`; legal range 1..65535.
- `clk_i` in 1: clock; all logic samples on the rising edge.
- `rst_i` in 1: synchronous, active-low reset.
- `core_req_i` in 1: core requests a data access.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: RISC-V funct3 encoding; 0 = LB/SB, 1 = LH/SH, 2 = LW/SW, 4 = LBU, 5 = LHU; codes 3, 6 and 7 are treated as word.
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, right-aligned.
- `core_rd_o` out 32: extended load result.
- `core_stall_o` out 1: stall to the core.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word address, with bits [1:0] forced to 00.
- `mem_wd_o` out 32: lane-replicated write data.
- `mem_rd_i` in 32: memory read word.
- `mem_ready_i` in 1: memory completes the access in this cycle.
- `err_o` out 1: one-cycle timeout pulse.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - When `core_req_i` = 1, latch addr, size, we and wd, then go to BUSY.
- BUSY:
  - `mem_req_o` = 1. Memory outputs are driven from the latched values.
  - When `mem_ready_i` = 1, capture the read data and go to DONE.
- DONE:
  - Go to IDLE unconditionally.
- `core_stall_o` = `core_req_i` & (state != DONE). This is combinational, so a new request stalls in its first cycle.
- Store lane mapping:
  - SB: `mem_be_o` = 0001 << a[1:0]; `mem_wd_o` = {4{wd[7:0]}}.
  - SH: `mem_be_o` = a[1] ? 1100 : 0011; `mem_wd_o` = {2{wd[15:0]}}.
  - SW: `mem_be_o` = 1111; `mem_wd_o` = wd.
- Load: `mem_be_o` follows the same mapping as stores for the given size; `mem_we_o` = 0.
- Load extraction, applied at capture:
  - Byte: `mem_rd_i` >> (8·a[1:0]), then [7:0] extended.
  - Half: a[1] selects [31:16] or [15:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the full word.
- Misaligned accesses have no trap:
  - Halfword ignores a[0].
  - Word ignores a[1:0].
- `core_rd_o` holds the last captured load value. Stores do not modify it.
- If `core_req_i` drops during BUSY, the transaction still completes. The result is written to `core_rd_o` but is not consumed by the core.

## Timing
- Reset values, at the first edge with `rst_i` = 0:
  - State = IDLE.
  - `mem_req_o`, `mem_we_o` and `err_o` = 0.
  - `mem_be_o` = 0000.
  - `mem_addr_o`, `mem_wd_o` and `core_rd_o` = 0.
  - Timeout counter = 0.
- Reset during BUSY: `mem_req_o` drops at that edge and the transaction is abandoned. The memory side must tolerate a request withdrawn without ready.
- Outside BUSY: `mem_req_o`, `mem_we_o` and `mem_be_o` are 0.
- Latency:
  - Request seen in IDLE at cycle 0; `mem_req_o` is high from cycle 1.
  - With `mem_ready_i` high at cycle 1, DONE is at cycle 2, with `core_stall_o` = 0 and `core_rd_o` valid.
  - Minimum is 3 cycles per access; each cycle of ready delay adds 1.
- The next request can be accepted in the IDLE cycle immediately after DONE, giving back-to-back accesses every 3 cycles.
- `mem_ready_i` is ignored outside BUSY.
- `mem_rd_i` is sampled only on the ready cycle.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When the count reaches `TIMEOUT_CYCLES` - 1 without ready, the FSM goes to DONE with `core_rd_o` = 32'hDEAD_BEEF; `mem_req_o` drops in that DONE cycle and `err_o` = 1 for that DONE cycle only.
  - Ready arriving on the final count cycle wins: normal completion, `err_o` = 0.
- `LSU_TIMEOUT_EN` not defined:
  - BUSY waits indefinitely.
  - The counter is absent and `err_o` is tied to 0.

## Test plan
- LW at 0x100, `mem_rd_i` = 0x8899AABB, ready at first BUSY cycle:
  - `mem_addr_o` = 0x100, `mem_be_o` = 1111, stall high for 2 cycles.
  - `core_rd_o` = 0x8899AABB in DONE.
- LB at 0x103 with `mem_rd_i` = 0x8899AABB: `core_rd_o` = 0xFFFFFF88. LBU at 0x103: `core_rd_o` = 0x00000088. LHU at 0x102: `core_rd_o` = 0x00008899.
- SB at 0x201, wd = 0x12345678: `mem_addr_o` = 0x200, `mem_be_o` = 0010, `mem_wd_o` = 0x78787878, `mem_we_o` = 1. SH at 0x202: `mem_be_o` = 1100, `mem_wd_o` = 0x56785678.
- Ready delayed 4 cycles: stall high for 6 cycles and `mem_req_o` high for 5. Reset asserted mid-BUSY: all outputs 0 at the next edge, and the FSM is in IDLE.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4 and no ready: DONE after 4 BUSY cycles, `core_rd_o` = 0xDEADBEEF, `err_o` pulses for 1 cycle, stall releases.
